// File: rtl/stage_rom_arbiter.sv
// stage_rom_arbiter: shares the stage-map ROM between the pixel renderer and
// two tile-query requesters. Render owns the slot by default, queries fill
// idle slots round-robin, and a query that waits MAX_WAIT cycles preempts
// the renderer for one slot. Row data and query answers return two cycles
// after the grant through a pipeline matched to the ROM's latency.
module stage_rom_arbiter #(
    parameter int unsigned AW         = 9,
    parameter int unsigned DW         = 32,
    parameter int unsigned NUM_STAGES = 16,
    parameter int unsigned MAX_WAIT   = 64,
    localparam int unsigned SW        = 4,
    localparam int unsigned TW        = 5
) (
    input  logic          clk,
    input  logic          rst_n,

    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,

    input  logic          r_en,
    input  logic [AW-1:0] r_addr,
    output logic          r_valid,
    output logic [DW-1:0] r_data,

    input  logic          q0_req,
    input  logic [SW-1:0] q0_stage,
    input  logic [TW-1:0] q0_tx,
    input  logic [TW-1:0] q0_ty,
    output logic          q0_ack,
    output logic          q0_hit,

    input  logic          q1_req,
    input  logic [SW-1:0] q1_stage,
    input  logic [TW-1:0] q1_tx,
    input  logic [TW-1:0] q1_ty,
    output logic          q1_ack,
    output logic          q1_hit
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    // Slot owner encoding
    localparam logic [1:0] OWN_NONE   = 2'd0;
    localparam logic [1:0] OWN_RENDER = 2'd1;
    localparam logic [1:0] OWN_Q0     = 2'd2;
    localparam logic [1:0] OWN_Q1     = 2'd3;

    // Per-slot bookkeeping carried alongside the ROM access
    typedef struct packed {
        logic [1:0]    owner;
        logic [TW-1:0] tx;
        logic          oor;
    } slotInfoT;

    logic [CW-1:0] wait0;
    logic [CW-1:0] wait1;
    logic [CW-1:0] wait0Next;
    logic [CW-1:0] wait1Next;
    logic          rrPtr;      // 0: q0 preferred, 1: q1 preferred
    logic          rrPtrNext;
    logic          gnt0Last;   // port granted in the previous cycle
    logic          gnt1Last;

    logic          elig0;
    logic          elig1;
    logic          starve0;
    logic          starve1;
    logic          oor0;
    logic          oor1;
    logic [1:0]    owner;

    logic [AW-1:0] addrNext;
    slotInfoT      slotNext;
    slotInfoT      slotQ;

    logic [DW-1:0] rowRev;
    logic          hitBit;

    // Column 0 is the MSB of a row; reverse so tx indexes directly
    assign rowRev = {<<{rom_data}};
    assign hitBit = rowRev[slotQ.tx];

    // Slot arbitration: starving query, then render, then round-robin queries
    always_comb begin
        elig0   = q0_req && !gnt0Last;
        elig1   = q1_req && !gnt1Last;
        starve0 = elig0 && (wait0 == WAIT_MAX);
        starve1 = elig1 && (wait1 == WAIT_MAX);
        oor0    = 32'(q0_stage) >= NUM_STAGES;
        oor1    = 32'(q1_stage) >= NUM_STAGES;
        owner   = OWN_NONE;

        if (starve0 && starve1) begin
            owner = rrPtr ? OWN_Q1 : OWN_Q0;
        end else if (starve0) begin
            owner = OWN_Q0;
        end else if (starve1) begin
            owner = OWN_Q1;
        end else if (r_en) begin
            owner = OWN_RENDER;
        end else if (elig0 && elig1) begin
            owner = rrPtr ? OWN_Q1 : OWN_Q0;
        end else if (elig0) begin
            owner = OWN_Q0;
        end else if (elig1) begin
            owner = OWN_Q1;
        end
    end

    // Next address, slot payload, round-robin pointer and wait counters
    always_comb begin
        addrNext       = rom_addr;
        slotNext.owner = owner;
        slotNext.tx    = '0;
        slotNext.oor   = 1'b0;
        rrPtrNext      = rrPtr;
        wait0Next      = wait0;
        wait1Next      = wait1;

        case (owner)
            OWN_RENDER: begin
                addrNext = r_addr;
            end
            OWN_Q0: begin
                addrNext     = AW'({q0_stage, q0_ty});
                slotNext.tx  = q0_tx;
                slotNext.oor = oor0;
                rrPtrNext    = 1'b1;
            end
            OWN_Q1: begin
                addrNext     = AW'({q1_stage, q1_ty});
                slotNext.tx  = q1_tx;
                slotNext.oor = oor1;
                rrPtrNext    = 1'b0;
            end
            default: begin
            end
        endcase

        if (!q0_req || (owner == OWN_Q0)) begin
            wait0Next = '0;
        end else if (wait0 != WAIT_MAX) begin
            wait0Next = wait0 + CW'(1);
        end

        if (!q1_req || (owner == OWN_Q1)) begin
            wait1Next = '0;
        end else if (wait1 != WAIT_MAX) begin
            wait1Next = wait1 + CW'(1);
        end
    end

    // Grant stage: ROM address, slot payload and arbitration state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            slotQ    <= '0;
            rrPtr    <= 1'b0;
            wait0    <= '0;
            wait1    <= '0;
            gnt0Last <= 1'b0;
            gnt1Last <= 1'b0;
        end else begin
            rom_addr <= addrNext;
            slotQ    <= slotNext;
            rrPtr    <= rrPtrNext;
            wait0    <= wait0Next;
            wait1    <= wait1Next;
            gnt0Last <= (owner == OWN_Q0);
            gnt1Last <= (owner == OWN_Q1);
        end
    end

    // Return stage: deliver ROM data to whichever user owned the slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            q0_ack  <= 1'b0;
            q0_hit  <= 1'b0;
            q1_ack  <= 1'b0;
            q1_hit  <= 1'b0;
        end else begin
            r_valid <= (slotQ.owner == OWN_RENDER);
            if (slotQ.owner == OWN_RENDER) begin
                r_data <= rom_data;
            end
            q0_ack <= (slotQ.owner == OWN_Q0);
            q0_hit <= (slotQ.owner == OWN_Q0) && (slotQ.oor || hitBit);
            q1_ack <= (slotQ.owner == OWN_Q1);
            q1_hit <= (slotQ.owner == OWN_Q1) && (slotQ.oor || hitBit);
        end
    end

endmodule

// File: tb/tb_stage_rom_arbiter.sv
// Directed bench for stage_rom_arbiter: vector table plus hand-written
// starvation and reset sequences against a small ROM model.
module tb_stage_rom_arbiter;

    logic        clk;
    logic        rst_n;
    logic [8:0]  rom_addr;
    logic [31:0] rom_data;
    logic        r_en;
    logic [8:0]  r_addr;
    logic        r_valid;
    logic [31:0] r_data;
    logic        q0_req;
    logic [3:0]  q0_stage;
    logic [4:0]  q0_tx;
    logic [4:0]  q0_ty;
    logic        q0_ack;
    logic        q0_hit;
    logic        q1_req;
    logic [3:0]  q1_stage;
    logic [4:0]  q1_tx;
    logic [4:0]  q1_ty;
    logic        q1_ack;
    logic        q1_hit;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:511];

    // ROM model: row for the registered address, sampled on the next edge
    assign rom_data = mem[rom_addr];

    stage_rom_arbiter #(
        .AW(9), .DW(32), .NUM_STAGES(10), .MAX_WAIT(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .r_en(r_en), .r_addr(r_addr), .r_valid(r_valid), .r_data(r_data),
        .q0_req(q0_req), .q0_stage(q0_stage), .q0_tx(q0_tx), .q0_ty(q0_ty),
        .q0_ack(q0_ack), .q0_hit(q0_hit),
        .q1_req(q1_req), .q1_stage(q1_stage), .q1_tx(q1_tx), .q1_ty(q1_ty),
        .q1_ack(q1_ack), .q1_hit(q1_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ren;
        logic [8:0]  raddr;
        logic        q0r;
        logic [3:0]  q0s;
        logic [4:0]  q0x;
        logic [4:0]  q0y;
        logic        q1r;
        logic [3:0]  q1s;
        logic [4:0]  q1x;
        logic [4:0]  q1y;
        logic [8:0]  eAddr;
        logic        eRv;
        logic [31:0] eRd;
        logic        eA0;
        logic        eH0;
        logic        eA1;
        logic        eH1;
    } vecT;

    vecT vq[$];

    function automatic vecT mk(input int ren, input int ra,
                               input int q0r, input int q0s, input int q0x, input int q0y,
                               input int q1r, input int q1s, input int q1x, input int q1y,
                               input int ea, input int erv, input logic [31:0] erd,
                               input int ea0, input int eh0, input int ea1, input int eh1);
        vecT v;
        v.ren = 1'(ren);   v.raddr = 9'(ra);
        v.q0r = 1'(q0r);   v.q0s = 4'(q0s);  v.q0x = 5'(q0x);  v.q0y = 5'(q0y);
        v.q1r = 1'(q1r);   v.q1s = 4'(q1s);  v.q1x = 5'(q1x);  v.q1y = 5'(q1y);
        v.eAddr = 9'(ea);  v.eRv = 1'(erv);  v.eRd = erd;
        v.eA0 = 1'(ea0);   v.eH0 = 1'(eh0);  v.eA1 = 1'(ea1);  v.eH1 = 1'(eh1);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r_en = 1'b0;   r_addr = '0;
        q0_req = 1'b0; q0_stage = '0; q0_tx = '0; q0_ty = '0;
        q1_req = 1'b0; q1_stage = '0; q1_tx = '0; q1_ty = '0;
    endtask

    task automatic drive(input vecT v);
        r_en = v.ren;   r_addr = v.raddr;
        q0_req = v.q0r; q0_stage = v.q0s; q0_tx = v.q0x; q0_ty = v.q0y;
        q1_req = v.q1r; q1_stage = v.q1s; q1_tx = v.q1x; q1_ty = v.q1y;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i] = 32'h1000_0000 + (32'(i) << 16) + 32'(i);
        end
        mem[35]  = 32'h8000_0000;
        mem[64]  = 32'h4000_0000;
        mem[97]  = 32'h0000_0001;
        mem[292] = 32'h0000_0000;
        mem[482] = 32'h0000_0000;

        // ren,ra, q0:r,s,x,y, q1:r,s,x,y, exp addr,rv,rd, a0,h0,a1,h1
        // render stream, rows 5,6,7
        vq.push_back(mk(1,5, 0,0,0,0, 0,0,0,0,   5,0,32'h0,        0,0,0,0));
        vq.push_back(mk(1,6, 0,0,0,0, 0,0,0,0,   6,1,32'h10050005, 0,0,0,0));
        vq.push_back(mk(1,7, 0,0,0,0, 0,0,0,0,   7,1,32'h10060006, 0,0,0,0));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,   7,1,32'h10070007, 0,0,0,0));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,   7,0,32'h0,        0,0,0,0));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,   7,0,32'h0,        0,0,0,0));
        // single q0 query, stage 1 row 3, tx 0 then tx 1
        vq.push_back(mk(0,0, 1,1,0,3, 0,0,0,0,  35,0,32'h0,        0,0,0,0));
        vq.push_back(mk(0,0, 1,1,0,3, 0,0,0,0,  35,0,32'h0,        1,1,0,0));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,  35,0,32'h0,        0,0,0,0));
        vq.push_back(mk(0,0, 1,1,1,3, 0,0,0,0,  35,0,32'h0,        0,0,0,0));
        vq.push_back(mk(0,0, 1,1,1,3, 0,0,0,0,  35,0,32'h0,        1,0,0,0));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,  35,0,32'h0,        0,0,0,0));
        // both queries held; pointer favours q1 after the q0 grants
        vq.push_back(mk(0,0, 1,2,1,0, 1,3,31,1, 97,0,32'h0,        0,0,0,0));
        vq.push_back(mk(0,0, 1,2,1,0, 1,3,31,1, 64,0,32'h0,        0,0,1,1));
        vq.push_back(mk(0,0, 1,2,1,0, 1,3,31,1, 97,0,32'h0,        1,1,0,0));
        vq.push_back(mk(0,0, 1,2,1,0, 1,3,31,1, 64,0,32'h0,        0,0,1,1));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,  64,0,32'h0,        1,1,0,0));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,  64,0,32'h0,        0,0,0,0));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,  64,0,32'h0,        0,0,0,0));
        // lone q0 held: granted every second cycle
        vq.push_back(mk(0,0, 1,2,1,0, 0,0,0,0,  64,0,32'h0,        0,0,0,0));
        vq.push_back(mk(0,0, 1,2,1,0, 0,0,0,0,  64,0,32'h0,        1,1,0,0));
        vq.push_back(mk(0,0, 1,2,1,0, 0,0,0,0,  64,0,32'h0,        0,0,0,0));
        vq.push_back(mk(0,0, 1,2,1,0, 0,0,0,0,  64,0,32'h0,        1,1,0,0));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,  64,0,32'h0,        0,0,0,0));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,  64,0,32'h0,        0,0,0,0));
        // render beats a waiting query, query takes the next idle slot
        vq.push_back(mk(1,5, 1,2,1,0, 0,0,0,0,   5,0,32'h0,        0,0,0,0));
        vq.push_back(mk(0,0, 1,2,1,0, 0,0,0,0,  64,1,32'h10050005, 0,0,0,0));
        vq.push_back(mk(0,0, 1,2,1,0, 0,0,0,0,  64,0,32'h0,        1,1,0,0));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,  64,0,32'h0,        0,0,0,0));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,  64,0,32'h0,        0,0,0,0));
        // stage 15 out of range: solid over an empty row
        vq.push_back(mk(0,0, 0,0,0,0, 1,15,0,2, 482,0,32'h0,       0,0,0,0));
        vq.push_back(mk(0,0, 0,0,0,0, 1,15,0,2, 482,0,32'h0,       0,0,1,1));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,  482,0,32'h0,       0,0,0,0));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,  482,0,32'h0,       0,0,0,0));
        // stage 9 is the last valid stage: ROM bit decides
        vq.push_back(mk(0,0, 1,9,0,4, 0,0,0,0,  292,0,32'h0,       0,0,0,0));
        vq.push_back(mk(0,0, 1,9,0,4, 0,0,0,0,  292,0,32'h0,       1,0,0,0));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,  292,0,32'h0,       0,0,0,0));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,  292,0,32'h0,       0,0,0,0));
        // stage 10 is the first invalid stage
        vq.push_back(mk(0,0, 0,0,0,0, 1,10,31,0, 320,0,32'h0,      0,0,0,0));
        vq.push_back(mk(0,0, 0,0,0,0, 1,10,31,0, 320,0,32'h0,      0,0,1,1));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,  320,0,32'h0,       0,0,0,0));
        vq.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,  320,0,32'h0,       0,0,0,0));

        // reset values
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        check("reset rom_addr", 32'(rom_addr), 32'd0);
        check("reset r_valid",  32'(r_valid),  32'd0);
        check("reset r_data",   r_data,        32'd0);
        check("reset q0_ack",   32'(q0_ack),   32'd0);
        check("reset q0_hit",   32'(q0_hit),   32'd0);
        check("reset q1_ack",   32'(q1_ack),   32'd0);
        check("reset q1_hit",   32'(q1_hit),   32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        foreach (vq[i]) begin
            drive(vq[i]);
            tick();
            check($sformatf("row%0d rom_addr", i), 32'(rom_addr), 32'(vq[i].eAddr));
            check($sformatf("row%0d r_valid", i),  32'(r_valid),  32'(vq[i].eRv));
            if (vq[i].eRv) check($sformatf("row%0d r_data", i), r_data, vq[i].eRd);
            check($sformatf("row%0d q0_ack", i), 32'(q0_ack), 32'(vq[i].eA0));
            if (vq[i].eA0) check($sformatf("row%0d q0_hit", i), 32'(q0_hit), 32'(vq[i].eH0));
            check($sformatf("row%0d q1_ack", i), 32'(q1_ack), 32'(vq[i].eA1));
            if (vq[i].eA1) check($sformatf("row%0d q1_hit", i), 32'(q1_hit), 32'(vq[i].eH1));
        end

        // starvation: q1 preempts continuous render on its 65th waiting cycle
        for (int k = 1; k <= 70; k++) begin
            idle();
            r_en     = 1'b1;
            r_addr   = 9'd6;
            q1_req   = (k <= 66);
            q1_stage = 4'd0;
            q1_tx    = 5'd3;
            q1_ty    = 5'd7;
            tick();
            check($sformatf("starve k%0d rom_addr", k), 32'(rom_addr), (k == 65) ? 32'd7 : 32'd6);
            check($sformatf("starve k%0d r_valid", k), 32'(r_valid),
                  ((k >= 2) && (k != 66)) ? 32'd1 : 32'd0);
            if ((k >= 2) && (k != 66)) begin
                check($sformatf("starve k%0d r_data", k), r_data, 32'h10060006);
            end
            check($sformatf("starve k%0d q1_ack", k), 32'(q1_ack), (k == 66) ? 32'd1 : 32'd0);
            if (k == 66) check("starve q1_hit", 32'(q1_hit), 32'd1);
        end
        idle();
        tick();

        // reset in the cycle after a q0 grant discards the in-flight ack
        q0_req = 1'b1; q0_stage = 4'd1; q0_tx = 5'd0; q0_ty = 5'd3;
        tick();
        check("midrst grant rom_addr", 32'(rom_addr), 32'd35);
        rst_n  = 1'b0;
        q0_req = 1'b0;
        #1;
        check("midrst rom_addr", 32'(rom_addr), 32'd0);
        check("midrst q0_ack",   32'(q0_ack),   32'd0);
        check("midrst r_valid",  32'(r_valid),  32'd0);
        tick();
        check("midrst q0_ack c1", 32'(q0_ack), 32'd0);
        tick();
        check("midrst q0_ack c2", 32'(q0_ack), 32'd0);
        rst_n = 1'b1;
        tick();
        check("postrst q0_ack",   32'(q0_ack),   32'd0);
        check("postrst rom_addr", 32'(rom_addr), 32'd0);

        // fresh requests after reset: pointer back at q0
        q0_req = 1'b1; q0_stage = 4'd1; q0_tx = 5'd0;  q0_ty = 5'd3;
        q1_req = 1'b1; q1_stage = 4'd3; q1_tx = 5'd31; q1_ty = 5'd1;
        tick();
        check("postrst first grant rom_addr", 32'(rom_addr), 32'd35);
        tick();
        check("postrst second grant rom_addr", 32'(rom_addr), 32'd97);
        check("postrst q0_ack", 32'(q0_ack), 32'd1);
        check("postrst q0_hit", 32'(q0_hit), 32'd1);
        q0_req = 1'b0;
        tick();
        check("postrst q0_ack drop", 32'(q0_ack), 32'd0);
        check("postrst q1_ack", 32'(q1_ack), 32'd1);
        check("postrst q1_hit", 32'(q1_hit), 32'd1);
        idle();
        tick();
        check("postrst q1_ack drop", 32'(q1_ack), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
